uart_load_ctrl: RTL

Boot-load controller between the UART byte receiver and the CPU's memory write port. On a load request it holds the CPU, packs received bytes into little-endian 32-bit words, and writes them to consecutive memory addresses. It ends the load on a word-count limit or a line-idle timeout, then returns the write port to the CPU. It owns the arbitration of the shared memory write port: the CPU in normal run, the loader during a load.

---
 rtl/loader_pkg.sv | 33 +++
 rtl/byte_packer.sv | 55 +++++
 rtl/uart_load_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the UART boot loader: the controller state
//   encoding, default sizing constants, and the byte-placement helper used
//   by the byte packer.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RECV  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } load_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 14;
    localparam int DEFAULT_MAX_WORDS  = 4096;

    // One UART bit time in clk cycles (57.6 MHz clock at 115200 baud).
    localparam int UART_BIT_CYCLES = 500;
    // Line-idle timeout: ten 10-bit character frames of silence.
    localparam int DEFAULT_IDLE_CYCLES = 100 * UART_BIT_CYCLES;

    // Return 'word' with byte lane 'idx' replaced by 'b' (little-endian lanes).
    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer
//   Assembles received bytes into little-endian 32-bit words.
//   Ports:
//     clk, reset   clock, asynchronous active-low reset
//     clear        drop any partial word and restart at byte lane 0
//     byte_valid   one-cycle strobe, byte_in is packed this cycle
//     byte_in      byte to pack
//     flush        emit the partial word (unfilled lanes zero); ignored if empty
//     byte_idx     lane the next byte will land in
//     word_valid   one-cycle pulse, word_data is a complete or flushed word
//     word_data    assembled word, valid with word_valid
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        flush,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [31:0] asm_q;
    logic [1:0]  idx_q;
    logic [31:0] merged;

    // The word leaves combinationally in the cycle its last byte arrives so
    // the caller can register it with the matching address in one step.
    always_comb begin
        merged     = place_byte(asm_q, idx_q, byte_in);
        word_valid = (byte_valid && (idx_q == 2'd3)) || (flush && (idx_q != 2'd0));
        word_data  = byte_valid ? merged : asm_q;
    end

    // The assembly register returns to zero after every emitted word, which
    // is what makes a flushed word zero-padded in its unreceived lanes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q <= '0;
            idx_q <= '0;
        end else if (clear || word_valid) begin
            asm_q <= '0;
            idx_q <= '0;
        end else if (byte_valid) begin
            asm_q <= merged;
            idx_q <= idx_q + 2'd1;
        end
    end

    assign byte_idx = idx_q;

endmodule

// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl
//   Boot-load controller between the UART byte receiver and the CPU memory
//   write port. A load request holds the CPU, packs received bytes into
//   little-endian words written to consecutive addresses from 0, and ends on
//   the word limit or a line-idle timeout. Outside a load the CPU owns the
//   memory write port.
//   Ports:
//     clk, reset                       clock, asynchronous active-low reset
//     load_req                         one-cycle start pulse (honoured in IDLE only)
//     rx_valid, rx_byte                received byte strobe and data
//     cpu_mem_we/addr/wdata            CPU write port request
//     mem_we/addr/wdata                arbitrated memory write port
//     cpu_hold                         CPU held while 1
//     busy                             controller not idle
//     load_done                        one-cycle pulse at end of load
//     word_count                       words written in the current/last load
//     dbg_state                        controller state, for observation
//
//   rx_valid is a strobe with no ready: the receiver cannot be stalled, so a
//   byte that arrives while the controller cannot take it is lost.
module uart_load_ctrl
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int MAX_WORDS   = DEFAULT_MAX_WORDS,
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  cpu_mem_we,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output load_state_t           dbg_state
);

    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    // The counter holds IDLE_CYCLES-1 in the last silent cycle; the
    // transition out of RECV takes effect on the following edge.
    localparam logic [IDLE_W-1:0]   IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] WORD_LIMIT = (ADDR_WIDTH + 1)'(MAX_WORDS);

    load_state_t             state_q, state_d;
    logic [IDLE_W-1:0]       idle_cnt_q;
    logic [ADDR_WIDTH:0]     word_count_q;
    logic                    lw_we_q;
    logic [ADDR_WIDTH-1:0]   lw_addr_q;
    logic [DATA_WIDTH-1:0]   lw_data_q;

    logic                    accept;
    logic                    pk_clear;
    logic                    pk_flush;
    logic                    at_limit;
    logic                    timeout;
    logic [1:0]              byte_idx;
    logic                    word_valid;
    logic [31:0]             word_data;

    assign at_limit = (word_count_q == WORD_LIMIT);
    assign timeout  = (idle_cnt_q == IDLE_LAST);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (accept),
        .byte_in    (rx_byte),
        .flush      (pk_flush),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        pk_clear = 1'b0;
        pk_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d  = ST_ARM;
                    pk_clear = 1'b1;
                end
            end
            ST_ARM: begin
                if (rx_valid) begin
                    state_d = ST_RECV;
                    accept  = 1'b1;
                end
            end
            ST_RECV: begin
                // The limit wins over any byte in flight; a byte arriving in
                // the timeout cycle cancels the timeout.
                if (at_limit) begin
                    state_d = ST_DONE;
                end else if (rx_valid) begin
                    accept = 1'b1;
                end else if (timeout) begin
                    state_d = (byte_idx != 2'd0) ? ST_FLUSH : ST_DONE;
                end
            end
            ST_FLUSH: begin
                pk_flush = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_q <= '0;
            idle_cnt_q   <= '0;
            lw_we_q      <= 1'b0;
            lw_addr_q    <= '0;
            lw_data_q    <= '0;
        end else begin
            lw_we_q <= word_valid;
            if (word_valid) begin
                lw_addr_q <= word_count_q[ADDR_WIDTH-1:0];
                lw_data_q <= word_data;
            end

            if (pk_clear)        word_count_q <= '0;
            else if (word_valid) word_count_q <= word_count_q + 1'b1;

            if ((state_q != ST_RECV) || rx_valid) idle_cnt_q <= '0;
            else if (!timeout)                    idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    // Write-port arbitration: the CPU request passes straight through only
    // in IDLE; otherwise it is discarded and the loader registers drive.
    always_comb begin
        if (state_q == ST_IDLE) begin
            mem_we    = cpu_mem_we;
            mem_addr  = cpu_mem_addr;
            mem_wdata = cpu_mem_wdata;
        end else begin
            mem_we    = lw_we_q;
            mem_addr  = lw_addr_q;
            mem_wdata = lw_data_q;
        end
    end

    assign cpu_hold   = (state_q != ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign load_done  = (state_q == ST_DONE);
    assign word_count = word_count_q;
    assign dbg_state  = state_q;

endmodule
